// File: rtl/s2mm_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : s2mm_packetizer
// Brief    : Frame-aligning output stage; buffers pixels and drives an
//            AXI4-Stream master with TLAST on the final pixel of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module s2mm_packetizer #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      m_axis_s2mm_aclk,
    input  logic                      m_axis_s2mm_aresetn,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     m_axis_s2mm_tdata,
    output logic                      m_axis_s2mm_tvalid,
    input  logic                      m_axis_s2mm_tready,
    output logic                      m_axis_s2mm_tlast,
    output logic [DATA_WIDTH/8-1:0]   m_axis_s2mm_tstrb,
    output logic                      frame_done,
    output logic                      sync_err,
    output logic [15:0]               frame_count
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_xw = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int c_yw = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [c_xw-1:0] c_x_max = c_xw'(FRAME_WIDTH - 1);
    localparam logic [c_yw-1:0] c_y_max = c_yw'(FRAME_HEIGHT - 1);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_run;
    logic [c_xw-1:0]       r_x;
    logic [c_yw-1:0]       r_y;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw:0]         r_count;
    logic                  r_frame_done;
    logic                  r_sync_err;
    logic [15:0]           r_frame_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_restart;
    logic [c_xw-1:0]       w_x;
    logic [c_yw-1:0]       w_y;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_mid_sof;
    logic [DATA_WIDTH:0]   w_head;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    // r_run keeps in_ready low until the first clock after reset release
    assign in_ready  = r_run & ~w_full;
    assign w_accept  = in_valid & in_ready;

    // Any in_sof re-anchors the pixel to (0,0), whether hunting or mid-frame
    assign w_restart = (r_state == HUNT) | in_sof;
    assign w_x       = w_restart ? '0 : r_x;
    assign w_y       = w_restart ? '0 : r_y;
    assign w_last    = (w_x == c_x_max) && (w_y == c_y_max);
    assign w_push    = w_accept & ((r_state == STREAM) | in_sof);
    assign w_mid_sof = w_accept & (r_state == STREAM) & in_sof
                       & ((r_x != '0) | (r_y != '0));

    assign w_head    = r_mem[r_rd_ptr];
    assign w_pop     = ~w_empty & m_axis_s2mm_tready;

    assign m_axis_s2mm_tvalid = ~w_empty;
    assign m_axis_s2mm_tdata  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m_axis_s2mm_tlast  = ~w_empty & w_head[DATA_WIDTH];
    assign m_axis_s2mm_tstrb  = '1;
    assign frame_done         = r_frame_done;
    assign sync_err           = r_sync_err;
    assign frame_count        = r_frame_count;

    always_ff @(posedge m_axis_s2mm_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, in_data};
        end
    end

    always_ff @(posedge m_axis_s2mm_aclk or negedge m_axis_s2mm_aresetn) begin
        if (!m_axis_s2mm_aresetn) begin
            r_run         <= 1'b0;
            r_state       <= HUNT;
            r_x           <= '0;
            r_y           <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_run        <= 1'b1;
            r_sync_err   <= w_mid_sof;
            r_frame_done <= w_pop & w_head[DATA_WIDTH];

            if (w_pop && w_head[DATA_WIDTH]) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                if (w_last) begin
                    r_state <= HUNT;
                    r_x     <= '0;
                    r_y     <= '0;
                end else begin
                    r_state <= STREAM;
                    if (w_x == c_x_max) begin
                        r_x <= '0;
                        r_y <= w_y + 1'b1;
                    end else begin
                        r_x <= w_x + 1'b1;
                        r_y <= w_y;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s2mm_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2mm_packetizer
// Brief    : Directed self-checking bench for s2mm_packetizer (4x2 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2mm_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic [3:0]  tstrb;
    logic        frame_done;
    logic        sync_err;
    logic [15:0] frame_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          rand_mode = 1'b0;
    logic [31:0] q_data [$];
    bit          q_last [$];
    int          n_done = 0;
    int          n_sync = 0;

    s2mm_packetizer #(
        .DATA_WIDTH   (32),
        .FRAME_WIDTH  (4),
        .FRAME_HEIGHT (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .m_axis_s2mm_aclk    (clk),
        .m_axis_s2mm_aresetn (rst_n),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_sof              (in_sof),
        .in_ready            (in_ready),
        .m_axis_s2mm_tdata   (tdata),
        .m_axis_s2mm_tvalid  (tvalid),
        .m_axis_s2mm_tready  (tready),
        .m_axis_s2mm_tlast   (tlast),
        .m_axis_s2mm_tstrb   (tstrb),
        .frame_done          (frame_done),
        .sync_err            (sync_err),
        .frame_count         (frame_count)
    );

    always #5 clk = ~clk;

    // Record every handshake and pulse on the falling edge, mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) begin
                q_data.push_back(tdata);
                q_last.push_back(tlast);
            end
            if (frame_done) n_done++;
            if (sync_err)   n_sync++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input bit sof);
        int guard;
        if (rand_mode) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("send_timeout", 32'(guard), 32'd0);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input int base, input logic [31:0] first,
                              input int n, input bit has_last);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = base + i;
            if (idx < q_data.size()) begin
                chk({tag, "_data"}, q_data[idx], first + 32'(i));
                chk({tag, "_last"}, 32'(q_last[idx]), 32'(has_last && (i == n - 1)));
            end else begin
                chk({tag, "_missing"}, 32'(idx), 32'(q_data.size()));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        int done0;
        int sync0;

        // ---- reset values ----
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_tstrb", 32'(tstrb), 32'hF);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // ---- basic frame, latency of one cycle ----
        base  = q_data.size();
        done0 = n_done;
        send(32'h00, 1'b1);
        chk("lat_tvalid", 32'(tvalid), 32'd1);
        chk("lat_tdata", tdata, 32'h00);
        for (int i = 1; i < 8; i++) send(32'(i), 1'b0);
        repeat (6) tick();
        chk("t1_words", 32'(q_data.size() - base), 32'd8);
        expect_seq("t1", base, 32'h00, 8, 1'b1);
        chk("t1_done", 32'(n_done - done0), 32'd1);
        chk("t1_fcount", 32'(frame_count), 32'd1);

        // ---- pixels before SOF are dropped ----
        base = q_data.size();
        for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), i == 0);
        repeat (6) tick();
        chk("t2_words", 32'(q_data.size() - base), 32'd8);
        expect_seq("t2", base, 32'h10, 8, 1'b1);
        chk("t2_fcount", 32'(frame_count), 32'd2);

        // ---- backpressure fills the FIFO ----
        base   = q_data.size();
        tready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h20 + 32'(i), i == 0);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_hold_tdata", tdata, 32'h20);
        in_valid = 1'b1;
        in_data  = 32'h24;
        repeat (3) tick();
        chk("t3_still_full", 32'(in_ready), 32'd0);
        chk("t3_still_hold", tdata, 32'h20);
        chk("t3_no_output", 32'(q_data.size() - base), 32'd0);
        tready = 1'b1;
        tick();
        chk("t3_ready_rise", 32'(in_ready), 32'd1);
        for (int i = 4; i < 8; i++) send(32'h20 + 32'(i), 1'b0);
        repeat (6) tick();
        chk("t3_words", 32'(q_data.size() - base), 32'd8);
        expect_seq("t3", base, 32'h20, 8, 1'b1);
        chk("t3_fcount", 32'(frame_count), 32'd3);

        // ---- SOF mid-frame restarts the frame ----
        base  = q_data.size();
        sync0 = n_sync;
        for (int i = 0; i < 3; i++) send(32'h30 + 32'(i), i == 0);
        send(32'h40, 1'b1);
        chk("t4_sync_pulse", 32'(sync_err), 32'd1);
        for (int i = 1; i < 8; i++) send(32'h40 + 32'(i), 1'b0);
        repeat (6) tick();
        chk("t4_sync_count", 32'(n_sync - sync0), 32'd1);
        chk("t4_words", 32'(q_data.size() - base), 32'd11);
        expect_seq("t4a", base, 32'h30, 3, 1'b0);
        expect_seq("t4b", base + 3, 32'h40, 8, 1'b1);
        chk("t4_fcount", 32'(frame_count), 32'd4);

        // ---- random gaps and backpressure over three frames ----
        do_reset();
        chk("t5_fcount_rst", 32'(frame_count), 32'd0);
        base      = q_data.size();
        done0     = n_done;
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) send(32'h50 + 32'(i), (i % 8) == 0);
        rand_mode = 1'b0;
        tready    = 1'b1;
        repeat (10) tick();
        chk("t5_words", 32'(q_data.size() - base), 32'd24);
        expect_seq("t5f0", base, 32'h50, 8, 1'b1);
        expect_seq("t5f1", base + 8, 32'h58, 8, 1'b1);
        expect_seq("t5f2", base + 16, 32'h60, 8, 1'b1);
        chk("t5_done", 32'(n_done - done0), 32'd3);
        chk("t5_fcount", 32'(frame_count), 32'd3);

        // ---- reset with words in flight ----
        tready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h70 + 32'(i), i == 0);
        chk("t6_buffered", 32'(tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid_async", 32'(tvalid), 32'd0);
        chk("t6_ready_rst", 32'(in_ready), 32'd0);
        chk("t6_fcount_rst", 32'(frame_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tready = 1'b1;
        base   = q_data.size();
        for (int i = 0; i < 8; i++) send(32'h80 + 32'(i), i == 0);
        repeat (6) tick();
        chk("t6_words", 32'(q_data.size() - base), 32'd8);
        expect_seq("t6", base, 32'h80, 8, 1'b1);
        chk("t6_fcount", 32'(frame_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
